// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcode encodings, FSM state encodings and the shared
// conditional-negate helper for the iterative multiply/divide unit.
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Widest value the helper handles; callers zero-extend in and truncate out,
  // which gives the correct two's complement at any narrower width.
  localparam int NEG_W = 128;

  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v,
                                                input logic             neg);
    return neg ? (~v + {{(NEG_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +----------------------------------------------------------------------+
// | muldiv_unit: iterative radix-2 signed/unsigned multiply and divide   |
// | into HI/LO with start/busy/done handshake and flush.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic             w_signed_op;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_sum;

  assign w_signed_op = ~op[0];
  assign w_abs_a = WIDTH'(cond_neg(NEG_W'(a), w_signed_op & a[WIDTH-1]));
  assign w_abs_b = WIDTH'(cond_neg(NEG_W'(b), w_signed_op & b[WIDTH-1]));

  // Divide: acc_q[WIDTH-1:0] holds the dividend shifting out and the quotient
  // shifting in; the trial subtraction is WIDTH+1 bits so its MSB is the borrow.
  assign w_shifted = {rem_q, acc_q[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, mcand_q};

  // Multiply: add the multiplicand into the upper half when the LSB is set.
  assign w_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !flush) begin
          state_d   = CALC;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_res_d = w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = w_signed_op & a[WIDTH-1];
          div0_d    = (b == '0);
          mcand_d   = w_abs_b;
          acc_d     = {{WIDTH{1'b0}}, w_abs_a};
          rem_d     = '0;
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            if (!w_diff[WIDTH]) begin
              rem_d = w_diff[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = w_shifted[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {w_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (is_div_q) begin
            // A zero divisor leaves |a| as the remainder, so the sign fix restores a.
            lo_d = div0_q ? {WIDTH{1'b1}}
                          : WIDTH'(cond_neg(NEG_W'(acc_q[WIDTH-1:0]), neg_res_q));
            hi_d = WIDTH'(cond_neg(NEG_W'(rem_q), neg_rem_q));
          end else begin
            {hi_d, lo_d} = (2*WIDTH)'(cond_neg(NEG_W'(acc_q), neg_res_q));
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed corner cases plus random operations for
// muldiv_unit, checked against a plain-arithmetic reference model.
`default_nettype none

module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit language arithmetic with the ISA's divide corner rules.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint     sx, sy, q, r;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = ux * uy; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (y == '0) begin
          el = '1;
          eh = x;
        end else if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  // Issues one op and returns at the negedge of its done cycle. With b2b set the
  // caller is already in a done cycle and start is driven there.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit poke, input bit b2b, input string tag);
    logic [W-1:0] eh, el;
    int k, gaps;
    model(o, x, y, eh, el);
    if (!b2b) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    k = 1;
    gaps = 0;
    while (!done && k < W + 8) begin
      if (!busy) gaps++;
      start = (poke && k == 4);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(k), 64'(W + 2));
    chk({tag, "_busygap"}, 64'(gaps), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    chk("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);

    // Stray start mid-operation must not yield a second done.
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, "mult_poke");
    dones = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mult_poke_extra_done", 64'(dones), 64'd0);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0, "divu_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_minm1");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, "div_zero_neg");

    // Preload hi/lo, then flush a DIVU at t+10.
    run_op(2'b11, 32'h0000_3412, 32'h0000_0100, 1'b0, 1'b0, "preload");
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd12345; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    dones = 0;
    for (int i = 0; i < W + 6; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(dones), 64'd0);
    chk("flush_hi", 64'(hi), 64'h12);
    chk("flush_lo", 64'(lo), 64'h34);

    // Flush together with start while idle: nothing accepted.
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);

    run_op(2'b01, 32'd7, 32'd9, 1'b0, 1'b0, "b2b_first");
    run_op(2'b00, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, "b2b_second");

    // Reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd11; b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);

    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom), pick(), pick(), 1'b0, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage, alongside the combinational ALU.
- Computes signed/unsigned multiply and divide over a parametrised WIDTH.
- Results go into internal HI/LO registers; a start/busy/done handshake lets the pipeline stall on busy.
- A flush input cancels an in-flight operation on exception or branch squash.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; even, >= 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an operation; sampled only when the unit is idle (IDLE or DONE).
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- flush  in  1  abort any operation in progress.
- busy  out  1  high while an accepted operation is computing.
- done  out  1  one-cycle pulse when HI/LO have been updated.
- hi  out  WIDTH  product upper half, or remainder.
- lo  out  WIDTH  product lower half, or quotient.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; hi=0, lo=0, busy=0, done=0; counter cleared. Reset overrides every other input, including mid-operation.
- States and transitions:
  - IDLE: start & ~flush -> CALC. Latch op, operand magnitudes (signed ops take |a|, |b|) and result-sign flags; counter=0.
  - CALC: one radix-2 step per cycle, for exactly WIDTH cycles.
    - Multiply: shift-add over a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract; partial remainder is WIDTH+1 bits.
  - CALC: counter==WIDTH-1 -> FIX.
  - FIX: apply signs, write hi/lo -> DONE.
  - DONE: done=1 for this cycle only. Behaves as IDLE: start & ~flush -> CALC, otherwise -> IDLE.
- Latency:
  - start high in cycle t (unit idle) -> busy=1 in cycles t+1..t+WIDTH+1.
  - done=1 and new hi/lo visible in cycle t+WIDTH+2.
  - busy=0 in the done cycle.
- Input stability: a, b and op are captured at acceptance; later changes have no effect. start while busy is ignored, with no queueing.
- flush:
  - In CALC or FIX: next state IDLE, busy=0, no done, hi/lo keep their previous values.
  - Together with start while idle: flush wins and nothing is accepted.
- Arithmetic rules:
  - Multiply: {hi,lo} = full 2*WIDTH product. Signed result is two's complement.
  - Divide: lo=quotient, hi=remainder. Signed quotient truncates toward zero; signed remainder takes the dividend's sign.
  - Divide by zero (either signedness): lo = all ones, hi = a as issued. No exception is raised.
  - Signed MIN/-1: lo = MIN (10...0), hi = 0; wrap, no trap.
- hi and lo change only in the FIX->DONE transition or on reset.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding constants: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum: IDLE, CALC, FIX, DONE.
- No sub-module is required; the datapath and FSM stay in muldiv_unit.
- A small helper function for conditional two's-complement negate belongs in the package.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at t -> done at t+34, hi=0xFFFFFFFE, lo=0x00000001; busy high t+1..t+33.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15); second start during busy is ignored and gives exactly one done.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x12, lo=0x34, then start DIVU; flush at t+10 -> busy=0 at t+11, no done pulse, hi/lo remain 0x12/0x34.
- Back-to-back: start asserted during the done cycle of a prior op -> accepted; second done lands WIDTH+2 cycles later. rst asserted mid-CALC -> hi=lo=0, busy=0 the next cycle.
